// File: rtl/conv_requant.sv
// conv_requant: per-lane rounding shift, optional ReLU and saturation of accumulator beats,
// buffered in a first-word-fall-through FIFO behind a stream master with early stall.
module conv_requant #(
   parameter int IN_W       = 20,
   parameter int OUT_W      = 8,
   parameter int LANES      = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_MARGIN  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_config_valid,
   output logic                   s_config_ready,
   input  logic [31:0]            s_config_data,
   input  logic [IN_W*LANES-1:0]  sum_data,
   input  logic                   sum_valid,
   output logic                   stall,
   output logic [OUT_W*LANES-1:0] m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_last,
   output logic                   done,
   output logic                   err_ovf,
   output logic [2:0]             status
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(-(1 << (OUT_W-1)));
   typedef enum logic [2:0] {IDLE = 3'd1, CFG1 = 3'd2, RUN = 3'd3, DRAIN = 3'd4, DONE = 3'd5} state_t;
   state_t state_q, state_d;
   logic relu_q, relu_d;
   logic [4:0] shift_q, shift_d;
   logic [31:0] total_len_q, total_len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, wr_cnt_q, wr_cnt_d;
   logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
   logic signed [IN_W:0] s1_q [LANES];
   logic signed [IN_W:0] s1_d [LANES];
   logic signed [IN_W:0] s2_q [LANES];
   logic signed [IN_W:0] s2_d [LANES];
   logic [OUT_W*LANES-1:0] s3_q, s3_d;
   logic [OUT_W*LANES:0] mem_q [FIFO_DEPTH];
   logic [OUT_W*LANES:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic err_q, err_d, stall_q, stall_d;
   logic signed [IN_W:0] rnd, lo;
   logic cfg_acc, pop, push, full, pipe_empty;
   assign s_config_ready = state_q == IDLE || state_q == CFG1;
   assign cfg_acc        = s_config_valid && s_config_ready;
   assign m_valid        = count_q != '0;
   assign full           = count_q == (AW+1)'(FIFO_DEPTH);
   assign pop            = m_valid && m_ready;
   assign push           = s3_v_q && (!full || pop);
   assign pipe_empty     = !s1_v_q && !s2_v_q && !s3_v_q;
   assign m_data         = mem_q[rd_ptr_q][OUT_W*LANES:1];
   assign m_last         = m_valid && mem_q[rd_ptr_q][0];
   assign done           = state_q == DONE;
   assign err_ovf        = err_q;
   assign stall          = stall_q;
   assign status         = state_q;
   always_comb begin
      rnd = shift_q == 5'd0 ? '0 : (IN_W+1)'(1) << (shift_q - 5'd1);
      lo  = relu_q ? '0 : SAT_LO;
      s3_d = '0;
      for (int i = 0; i < LANES; i++) begin
         s1_d[i] = $signed({sum_data[(LANES-1-i)*IN_W+IN_W-1], sum_data[(LANES-1-i)*IN_W +: IN_W]}) + rnd;
         s2_d[i] = s1_q[i] >>> shift_q;
         s3_d[(LANES-1-i)*OUT_W +: OUT_W] = s2_q[i] > SAT_HI ? SAT_HI[OUT_W-1:0] :
                                            s2_q[i] < lo ? lo[OUT_W-1:0] : s2_q[i][OUT_W-1:0];
      end
      s1_v_d = sum_valid && state_q == RUN;
      s2_v_d = s1_v_q;
      s3_v_d = s2_v_q;
   end
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {s3_q, wr_cnt_q + 32'd1 == total_len_q};
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      err_d    = err_q || (s3_v_q && full && !pop);
      // counts beats still in the pipeline so upstream stops before they can overflow
      stall_d  = 32'(count_q) + 32'(s1_v_q) + 32'(s2_v_q) + 32'(s3_v_q) >= 32'(FIFO_DEPTH - AF_MARGIN);
   end
   always_comb begin
      state_d     = state_q;
      relu_d      = relu_q;
      shift_d     = shift_q;
      total_len_d = total_len_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q + 32'(pop);
      wr_cnt_d    = wr_cnt_q + 32'(s3_v_q);
      case (state_q)
         IDLE: if (cfg_acc) begin
            relu_d  = s_config_data[31];
            shift_d = s_config_data[28:24];
            state_d = CFG1;
         end
         CFG1: if (cfg_acc) begin
            total_len_d = s_config_data;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            wr_cnt_d    = '0;
            state_d     = s_config_data == '0 ? DONE : RUN;
         end
         RUN: if (sum_valid) begin
            in_cnt_d = in_cnt_q + 32'd1;
            if (in_cnt_q + 32'd1 == total_len_q) state_d = DRAIN;
         end
         // dropped beats never reach the output, so an overflow also lets the drain finish
         DRAIN: if (pipe_empty && count_q == '0 && (out_cnt_q == total_len_q || err_q)) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         relu_q      <= 1'b0;
         shift_q     <= '0;
         total_len_q <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         s3_v_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         relu_q      <= relu_d;
         shift_q     <= shift_d;
         total_len_q <= total_len_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         s1_v_q      <= s1_v_d;
         s2_v_q      <= s2_v_d;
         s3_v_q      <= s3_v_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         err_q       <= err_d;
         stall_q     <= stall_d;
      end
   end
   always_ff @(posedge clk) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_conv_requant.sv
// tb_conv_requant: scoreboard bench for conv_requant; expected beats are queued when driven
// and compared as they leave the output stream.
module tb_conv_requant;
   localparam int IN_W = 20;
   localparam int OUT_W = 8;
   localparam int LANES = 64;
   localparam int DW = OUT_W*LANES;
   typedef struct {logic [DW-1:0] d; logic l;} exp_t;
   logic clk = 1'b0, rst, s_config_valid, s_config_ready, sum_valid, stall, m_valid, m_ready, m_last, done, err_ovf;
   logic [31:0] s_config_data;
   logic [IN_W*LANES-1:0] sum_data;
   logic [DW-1:0] m_data, last_obs;
   logic [2:0] status;
   exp_t sb [$];
   int n_chk = 0, n_pass = 0, n_out = 0;
   int lv [LANES];
   int cur_sh;
   bit cur_relu;
   always #5 clk = ~clk;
   conv_requant dut (
      .clk(clk), .rst(rst), .s_config_valid(s_config_valid), .s_config_ready(s_config_ready),
      .s_config_data(s_config_data), .sum_data(sum_data), .sum_valid(sum_valid), .stall(stall),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .done(done),
      .err_ovf(err_ovf), .status(status)
   );
   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask
   function automatic logic [OUT_W-1:0] rq(input longint x);
      longint d, r, q;
      d = longint'(1) << cur_sh;
      r = x + (cur_sh == 0 ? 0 : d / 2);
      q = r / d;
      if (r < 0 && q * d != r) q--;
      if (cur_relu && q < 0) q = 0;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return OUT_W'(q);
   endfunction
   function automatic logic [OUT_W-1:0] lane(input logic [DW-1:0] v, input int i);
      return v[(LANES-1-i)*OUT_W +: OUT_W];
   endfunction
   task automatic nxt;
      @(posedge clk);
      #1;
   endtask
   task automatic rand_lanes;
      for (int i = 0; i < LANES; i++) lv[i] = int'($urandom_range(0, 1048575)) - 524288;
   endtask
   task automatic beat(input bit exp_en, input bit last);
      exp_t e;
      for (int i = 0; i < LANES; i++) begin
         sum_data[(LANES-1-i)*IN_W +: IN_W] = IN_W'(lv[i]);
         e.d[(LANES-1-i)*OUT_W +: OUT_W] = rq(longint'(lv[i]));
      end
      e.l = last;
      if (exp_en) sb.push_back(e);
      sum_valid = 1'b1;
   endtask
   task automatic cfg(input logic [31:0] w0, input logic [31:0] w1);
      cur_relu = w0[31];
      cur_sh = int'(w0[28:24]);
      s_config_valid = 1'b1;
      s_config_data = w0;
      nxt;
      s_config_data = w1;
      nxt;
      s_config_valid = 1'b0;
   endtask
   task automatic wait_idle(input string tag, output int dn);
      int n = 0;
      dn = 0;
      do begin
         @(negedge clk);
         dn += int'(done);
         n++;
      end while (status != 3'd1 && n < 300);
      check(tag, n < 300, 1);
      nxt;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst && m_valid && m_ready) begin
         n_out++;
         last_obs = m_data;
         if (sb.size() == 0) check("unexpected_beat", 1, 0);
         else begin
            e = sb.pop_front();
            check("beat_data", m_data, e.d);
            check("beat_last", m_last, e.l);
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int dn, n, sent, first_stall, first_err, outs0;
      rst = 1'b1; s_config_valid = 1'b0; s_config_data = '0; sum_data = '0; sum_valid = 1'b0; m_ready = 1'b1;
      nxt; nxt;
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", s_config_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_mvalid", m_valid, 0);
      check("rst_mlast", m_last, 0);
      check("rst_done", done, 0);
      check("rst_err", err_ovf, 0);
      check("rst_status", status, 1);
      nxt;
      // relu + shift 3, single beat
      cfg(32'h8300_0000, 1);
      rand_lanes; lv[0] = 21; lv[1] = -21; lv[2] = 2000;
      beat(1, 1);
      nxt;
      sum_valid = 1'b0;
      wait_idle("t1_idle", dn);
      check("t1_done_pulses", dn, 1);
      check("t1_lane0", lane(last_obs, 0), 8'd3);
      check("t1_lane1", lane(last_obs, 1), 8'd0);
      check("t1_lane2", lane(last_obs, 2), 8'd127);
      check("t1_status", status, 1);
      // shift 0, saturation, latency
      cfg(32'h0000_0000, 1);
      rand_lanes; lv[0] = -200; lv[1] = 50; lv[2] = 127; lv[3] = -128;
      beat(1, 1);
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      sum_valid = 1'b0;
      check("t2_latency", n, 4);
      wait_idle("t2_idle", dn);
      check("t2_lane0", lane(last_obs, 0), 8'h80);
      check("t2_lane1", lane(last_obs, 1), 8'd50);
      check("t2_lane2", lane(last_obs, 2), 8'd127);
      check("t2_lane3", lane(last_obs, 3), 8'h80);
      // rounding shift 1
      cfg(32'h0100_0000, 1);
      rand_lanes; lv[0] = 1; lv[1] = 3; lv[2] = -1; lv[3] = -3;
      beat(1, 1);
      nxt;
      sum_valid = 1'b0;
      wait_idle("t3_idle", dn);
      check("t3_lane0", lane(last_obs, 0), 8'd1);
      check("t3_lane1", lane(last_obs, 1), 8'd2);
      check("t3_lane2", lane(last_obs, 2), 8'd0);
      check("t3_lane3", lane(last_obs, 3), 8'hff);
      // backpressure with stall-respecting source
      cfg(32'h0200_0000, 32);
      m_ready = 1'b0;
      sent = 0; first_stall = -1;
      for (int k = 0; k < 400 && !(sent == 32 && sb.size() == 0); k++) begin
         if (stall && first_stall < 0) first_stall = sent;
         if (k == 40) m_ready = 1'b1;
         if (!stall && sent < 32) begin
            rand_lanes;
            beat(1, sent == 31);
            sent++;
         end else sum_valid = 1'b0;
         nxt;
      end
      sum_valid = 1'b0;
      check("bp_stall_at", first_stall, 13);
      check("bp_sent", sent, 32);
      check("bp_sb_empty", sb.size(), 0);
      check("bp_err", err_ovf, 0);
      wait_idle("bp_idle", dn);
      check("bp_done_pulses", dn, 1);
      // overflow: source ignores stall
      cfg(32'h0000_0000, 20);
      m_ready = 1'b0;
      first_err = -1;
      for (int k = 0; k < 28; k++) begin
         if (k < 20) begin
            rand_lanes;
            beat(k < 16, 0);
         end else sum_valid = 1'b0;
         @(negedge clk);
         if (err_ovf && first_err < 0) first_err = k;
         nxt;
      end
      check("ovf_err_cycle", first_err, 20);
      outs0 = n_out;
      m_ready = 1'b1;
      wait_idle("ovf_idle", dn);
      check("ovf_done_pulses", dn, 1);
      check("ovf_beats_out", n_out - outs0, 16);
      check("ovf_sb_empty", sb.size(), 0);
      check("ovf_err_sticky", err_ovf, 1);
      // reset mid-job with buffered beats
      cfg(32'h0000_0000, 32);
      m_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rand_lanes;
         beat(1, 0);
         nxt;
      end
      sum_valid = 1'b0;
      repeat (6) nxt;
      rst = 1'b1;
      nxt;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("mrst_mvalid", m_valid, 0);
      check("mrst_status", status, 1);
      check("mrst_ready", s_config_ready, 1);
      check("mrst_err", err_ovf, 0);
      nxt;
      m_ready = 1'b1;
      outs0 = n_out;
      cfg(32'h8300_0000, 1);
      rand_lanes;
      beat(1, 1);
      nxt;
      sum_valid = 1'b0;
      wait_idle("mrst_idle", dn);
      check("mrst_beats_out", n_out - outs0, 1);
      check("mrst_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
